// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the instruction fetch stage.
//   fetch_state_t    : FSM state encoding (IDLE, REQ, WAIT, DONE, FAULT)
//   PC_INC           : PC step per completed fetch (16-bit instructions)
//   DEFAULT_TIMEOUT  : default mem_ready wait limit before FAULT
//   DEFAULT_RESET_PC : default PC after reset
package fetch_stage_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DONE,
    S_FAULT
  } fetch_state_t;

  localparam logic [15:0] PC_INC           = 16'd2;
  localparam int unsigned DEFAULT_TIMEOUT  = 15;
  localparam logic [15:0] DEFAULT_RESET_PC = 16'h0000;

endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter register for the fetch stage.
// Ports:
//   clk       : clock, rising edge
//   rst       : asynchronous active-high reset, loads RESET_PC
//   inc       : advance PC by PC_INC (16-bit wrap)
//   load      : load load_addr (halfword aligned); has priority over inc
//   load_addr : branch/jump destination
//   pc        : current program counter
module fetch_pc_reg
  import fetch_stage_pkg::*;
#(
  parameter logic [15:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inc,
  input  logic        load,
  input  logic [15:0] load_addr,
  output logic [15:0] pc
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc <= RESET_PC;
    end else if (load) begin
      // Instructions are halfword aligned; bit 0 of the target is dropped.
      pc <= load_addr & 16'hFFFE;
    end else if (inc) begin
      pc <= pc + PC_INC;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: reads one 16-bit instruction per request from
// memory, with a bounded wait for mem_ready and a sticky FAULT on timeout.
// Ports:
//   CLK           : clock, rising edge
//   reset         : asynchronous active-high reset
//   fetch_req     : request next instruction (sampled in IDLE only)
//   pc_load_en    : load branch_target into PC (IDLE and DONE only)
//   branch_target : branch/jump destination
//   fault_clr     : leave FAULT back to IDLE
//   mem_rdata     : instruction word from memory
//   mem_ready     : memory read data valid this cycle
//   mem_rd        : memory read strobe (REQ, WAIT)
//   mem_addr      : memory address, always the PC
//   instr         : captured instruction word
//   irw           : one-cycle pulse when instr is newly valid
//   pc_out        : address of the instruction held in instr
//   busy          : high in REQ, WAIT, DONE
//   fault         : high in FAULT
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int unsigned TIMEOUT  = DEFAULT_TIMEOUT,
  parameter logic [15:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic        fetch_req,
  input  logic        pc_load_en,
  input  logic [15:0] branch_target,
  input  logic        fault_clr,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ready,
  output logic        mem_rd,
  output logic [15:0] mem_addr,
  output logic [15:0] instr,
  output logic        irw,
  output logic [15:0] pc_out,
  output logic        busy,
  output logic        fault
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  fetch_state_t   state;
  logic [CW-1:0]  wait_cnt;
  logic [15:0]    pc;
  logic           pc_load;
  logic           pc_inc;

  // Branch loads are only accepted while no transaction is in flight,
  // so the address presented to memory never moves mid-read.
  assign pc_load = pc_load_en && (state == S_IDLE || state == S_DONE);
  assign pc_inc  = (state == S_DONE);

  fetch_pc_reg #(
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk       (CLK),
    .rst       (reset),
    .inc       (pc_inc),
    .load      (pc_load),
    .load_addr (branch_target),
    .pc        (pc)
  );

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      wait_cnt <= '0;
      instr    <= '0;
      pc_out   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          wait_cnt <= '0;
          if (fetch_req) state <= S_REQ;
        end
        S_REQ: begin
          if (mem_ready) begin
            instr  <= mem_rdata;
            pc_out <= pc;
            state  <= S_DONE;
          end else begin
            wait_cnt <= CW'(1);
            state    <= S_WAIT;
          end
        end
        S_WAIT: begin
          // Data arriving on the last allowed cycle still counts as a capture.
          if (mem_ready) begin
            instr  <= mem_rdata;
            pc_out <= pc;
            state  <= S_DONE;
          end else if (wait_cnt == CW'(TIMEOUT)) begin
            state <= S_FAULT;
          end else begin
            wait_cnt <= wait_cnt + CW'(1);
          end
        end
        S_DONE: begin
          wait_cnt <= '0;
          state    <= S_IDLE;
        end
        S_FAULT: begin
          wait_cnt <= '0;
          if (fault_clr) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign mem_rd   = (state == S_REQ) || (state == S_WAIT);
  assign mem_addr = pc;
  assign irw      = (state == S_DONE);
  assign busy     = (state == S_REQ) || (state == S_WAIT) || (state == S_DONE);
  assign fault    = (state == S_FAULT);

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios followed by
// randomized fetches, checked against a transaction-level model of the PC,
// captured instruction and per-cycle handshake expectations.
module tb_fetch_stage;

  localparam int unsigned TO  = 15;
  localparam logic [15:0] RPC = 16'h0000;

  logic        clk;
  logic        reset;
  logic        fetch_req;
  logic        pc_load_en;
  logic [15:0] branch_target;
  logic        fault_clr;
  logic [15:0] mem_rdata;
  logic        mem_ready;
  logic        mem_rd;
  logic [15:0] mem_addr;
  logic [15:0] instr;
  logic        irw;
  logic [15:0] pc_out;
  logic        busy;
  logic        fault;

  fetch_stage #(
    .TIMEOUT  (TO),
    .RESET_PC (RPC)
  ) dut (
    .CLK           (clk),
    .reset         (reset),
    .fetch_req     (fetch_req),
    .pc_load_en    (pc_load_en),
    .branch_target (branch_target),
    .fault_clr     (fault_clr),
    .mem_rdata     (mem_rdata),
    .mem_ready     (mem_ready),
    .mem_rd        (mem_rd),
    .mem_addr      (mem_addr),
    .instr         (instr),
    .irw           (irw),
    .pc_out        (pc_out),
    .busy          (busy),
    .fault         (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_pass;
  int unsigned n_total;

  // Reference model state.
  logic [15:0] m_pc;
  logic [15:0] m_instr;
  logic [15:0] m_pcout;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // One fetch transaction. Entered and left at a negedge with the DUT idle.
  // d: index of the read-strobe cycle in which mem_ready is raised;
  // d > TO means memory never answers.
  task automatic do_fetch(input int unsigned d, input logic [15:0] data,
                          input bit ld_done, input logic [15:0] tgt);
    logic [15:0] start_pc;
    start_pc = m_pc;
    check("idle_mem_rd", mem_rd, 0);
    check("idle_busy", busy, 0);
    check("idle_addr", mem_addr, m_pc);
    fetch_req = 1'b1;
    mem_rdata = 16'($urandom);
    @(negedge clk);
    fetch_req = 1'b0;
    for (int k = 0; k <= int'(TO); k++) begin
      check("rd_mem_rd", mem_rd, 1);
      check("rd_addr", mem_addr, start_pc);
      check("rd_irw", irw, 0);
      check("rd_busy", busy, 1);
      check("rd_fault", fault, 0);
      // Requests and branch loads during a transaction must be ignored.
      fetch_req     = 1'($urandom_range(0, 1));
      pc_load_en    = 1'($urandom_range(0, 1));
      branch_target = 16'($urandom);
      if (k == int'(d)) begin
        mem_ready = 1'b1;
        mem_rdata = data;
      end else begin
        mem_ready = 1'b0;
        mem_rdata = 16'($urandom);
      end
      @(negedge clk);
      mem_ready  = 1'b0;
      fetch_req  = 1'b0;
      pc_load_en = 1'b0;
      if (k == int'(d)) break;
    end
    if (d > TO) begin
      for (int j = 0; j < 2; j++) begin
        check("flt_fault", fault, 1);
        check("flt_mem_rd", mem_rd, 0);
        check("flt_busy", busy, 0);
        check("flt_instr", instr, m_instr);
        check("flt_addr", mem_addr, start_pc);
        pc_load_en    = 1'b1;
        fetch_req     = 1'b1;
        branch_target = 16'($urandom);
        @(negedge clk);
        pc_load_en = 1'b0;
        fetch_req  = 1'b0;
      end
      check("flt_sticky", fault, 1);
      fault_clr = 1'b1;
      @(negedge clk);
      fault_clr = 1'b0;
      check("clr_fault", fault, 0);
      check("clr_addr", mem_addr, m_pc);
      check("clr_busy", busy, 0);
    end else begin
      m_instr = data;
      m_pcout = start_pc;
      m_pc    = ld_done ? (tgt & 16'hFFFE) : start_pc + 16'd2;
      check("done_irw", irw, 1);
      check("done_instr", instr, m_instr);
      check("done_pc_out", pc_out, m_pcout);
      check("done_busy", busy, 1);
      check("done_mem_rd", mem_rd, 0);
      pc_load_en    = ld_done;
      branch_target = tgt;
      mem_rdata     = 16'($urandom);
      @(negedge clk);
      pc_load_en = 1'b0;
      check("post_irw", irw, 0);
      check("post_addr", mem_addr, m_pc);
      check("post_instr", instr, m_instr);
      check("post_pc_out", pc_out, m_pcout);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_pass        = 0;
    n_total       = 0;
    reset         = 1'b1;
    fetch_req     = 1'b0;
    pc_load_en    = 1'b0;
    branch_target = '0;
    fault_clr     = 1'b0;
    mem_rdata     = '0;
    mem_ready     = 1'b0;
    m_pc          = RPC;
    m_instr       = '0;
    m_pcout       = '0;
    repeat (2) @(negedge clk);
    check("rst_mem_rd", mem_rd, 0);
    check("rst_irw", irw, 0);
    check("rst_busy", busy, 0);
    check("rst_fault", fault, 0);
    check("rst_instr", instr, 16'h0000);
    check("rst_pc_out", pc_out, 16'h0000);
    check("rst_addr", mem_addr, RPC);
    reset = 1'b0;
    @(negedge clk);

    // Zero-wait fetch, delayed fetch, timeout, branch in DONE, boundary wait.
    do_fetch(0, 16'h02AF, 1'b0, 16'h0000);
    do_fetch(3, 16'h1234, 1'b0, 16'h0000);
    do_fetch(TO + 1, 16'h0000, 1'b0, 16'h0000);
    do_fetch(1, 16'hBEEF, 1'b1, 16'h0041);
    check("branch_pc", mem_addr, 16'h0040);
    do_fetch(TO, 16'h5A5A, 1'b0, 16'h0000);

    // Wrap from 16'hFFFE via an IDLE load with an odd target.
    pc_load_en    = 1'b1;
    branch_target = 16'hFFFF;
    @(negedge clk);
    pc_load_en = 1'b0;
    m_pc = 16'hFFFE;
    check("idle_load", mem_addr, 16'hFFFE);
    do_fetch(1, 16'hC0DE, 1'b0, 16'h0000);
    check("wrap_pc", mem_addr, 16'h0000);

    // Randomized traffic with idle gaps, idle loads and junk read data.
    for (int t = 0; t < 40; t++) begin
      int unsigned r;
      int unsigned d;
      int unsigned gap;
      gap = $urandom_range(0, 2);
      for (int g = 0; g < int'(gap); g++) begin
        pc_load_en    = 1'($urandom_range(0, 1));
        branch_target = 16'($urandom);
        mem_rdata     = 16'($urandom);
        mem_ready     = 1'($urandom_range(0, 1));
        if (pc_load_en) m_pc = branch_target & 16'hFFFE;
        @(negedge clk);
        pc_load_en = 1'b0;
        mem_ready  = 1'b0;
        check("gap_instr", instr, m_instr);
        check("gap_irw", irw, 0);
        check("gap_addr", mem_addr, m_pc);
      end
      r = $urandom_range(0, 9);
      if (r < 6)       d = $urandom_range(0, 4);
      else if (r == 6) d = TO;
      else if (r == 7) d = TO + 1;
      else             d = $urandom_range(5, TO - 1);
      do_fetch(d, 16'($urandom), 1'($urandom_range(0, 1)), 16'($urandom));
    end

    // Reset in the middle of a wait: strobe drops at once, nothing captured.
    fetch_req = 1'b1;
    @(negedge clk);
    fetch_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("wait_mem_rd", mem_rd, 1);
    reset = 1'b1;
    #1;
    check("arst_mem_rd", mem_rd, 0);
    check("arst_irw", irw, 0);
    check("arst_busy", busy, 0);
    check("arst_addr", mem_addr, RPC);
    check("arst_instr", instr, 16'h0000);
    @(negedge clk);
    reset   = 1'b0;
    m_pc    = RPC;
    m_instr = '0;
    m_pcout = '0;
    @(negedge clk);
    check("arst_no_irw", irw, 0);
    do_fetch(0, 16'h7E57, 1'b0, 16'h0000);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter TIMEOUT, default 15, maximum wait cycles for mem_ready before fault.
REQ-002 Parameter RESET_PC, default 16'h0000, PC value after reset.
REQ-003 CLK  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 fetch_req  input  1  control unit requests next instruction; sampled only in IDLE.
REQ-006 pc_load_en  input  1  load branch_target into PC; honoured only in IDLE and DONE.
REQ-007 branch_target  input  16  branch/jump destination address.
REQ-008 fault_clr  input  1  clears FAULT, returns to IDLE.
REQ-009 mem_rdata  input  16  instruction word from memory.
REQ-010 mem_ready  input  1  memory read data valid this cycle.
REQ-011 mem_rd  output  1  memory read strobe.
REQ-012 mem_addr  output  16  memory address; always equals PC.
REQ-013 instr  output  16  registered instruction word; feeds stage-3 instr.
REQ-014 irw  output  1  one-cycle pulse when instr is newly valid; feeds stage-3 irw.
REQ-015 pc_out  output  16  address of the instruction currently held in instr.
REQ-016 busy  output  1  high in REQ, WAIT, DONE.
REQ-017 fault  output  1  high in FAULT.

Function
REQ-018 FSM states IDLE, REQ, WAIT, DONE, FAULT; outputs decoded from registered state.
REQ-019 IDLE: fetch_req=1 -> REQ; else stay; mem_rd=0.
REQ-020 REQ: mem_rd=1; mem_ready=1 -> capture mem_rdata into instr, PC into pc_out, go DONE; else go WAIT with wait counter=1.
REQ-021 WAIT: mem_rd=1; mem_ready=1 -> capture and go DONE; else counter increments; counter==TIMEOUT with no mem_ready -> FAULT.
REQ-022 mem_ready arriving on the same cycle the counter reaches TIMEOUT is a capture, not a fault.
REQ-023 DONE: irw=1 for exactly one cycle; PC <= PC+2 (16-bit wrap, 16'hFFFE -> 16'h0000); next state IDLE.
REQ-024 pc_load_en in IDLE or DONE: PC <= {branch_target[15:1],1'b0}; in DONE the load overrides the +2 increment.
REQ-025 pc_load_en in REQ, WAIT or FAULT is ignored; PC and mem_addr stay stable during a transaction.
REQ-026 fetch_req outside IDLE is ignored (not queued).
REQ-027 FAULT: mem_rd=0, instr/PC held; sticky until fault_clr=1 -> IDLE (or reset).
REQ-028 instr and pc_out change only on capture; held otherwise.
REQ-029 Minimum latency: fetch_req sampled at edge n -> irw high in cycle n+2 for zero-wait memory.
REQ-030 mem_rdata ignored whenever mem_rd=0.

Reset
REQ-031 reset=1 forces, asynchronously: state IDLE, PC=RESET_PC, instr=16'h0000, pc_out=16'h0000, counter=0, mem_rd=0, irw=0, busy=0, fault=0.
REQ-032 Reset asserted mid-REQ/WAIT deasserts mem_rd immediately; no capture occurs.
REQ-033 First fetch after reset release reads address RESET_PC.

Structure
REQ-034 Shared package holds state encoding typedef, PC_INC=2, default TIMEOUT, default RESET_PC.
REQ-035 PC register with increment/load mux is one sub-module, fetch_pc_reg; FSM and counter stay in fetch_stage.

Verification
REQ-036 Reset, fetch_req=1 one cycle, mem_ready=1 in REQ, mem_rdata=16'h02AF -> irw pulse 2 cycles after request, instr=16'h02AF, pc_out=0, PC=2.
REQ-037 mem_ready delayed 3 cycles, mem_rdata=16'h1234 -> mem_rd high 4 cycles, mem_addr stable, single irw pulse, instr=16'h1234.
REQ-038 mem_ready never asserted -> fault=1 after REQ+15 WAIT cycles, mem_rd=0; fault_clr -> IDLE, fault=0, PC unchanged.
REQ-039 pc_load_en=1 branch_target=16'h0041 in DONE -> PC=16'h0040 (not +2); pc_load_en in WAIT -> PC unchanged.
REQ-040 PC=16'hFFFE fetch completes -> PC wraps to 16'h0000; reset asserted during WAIT -> mem_rd=0 same cycle, PC=RESET_PC, no irw.
